// File: rtl/si5340_i2c_master.sv
// Write-only I2C byte master: one byte per command with optional START/STOP, open-drain pads.
// Define SI5340_I2C_STRETCH_EN to make the quarter counter honour slave clock stretching on SCL.

module si5340_i2c_master #(
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int I2C_FREQ_HZ = 400_000
) (
  input  logic       clk_i,
  input  logic       arstn_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_start_i,
  input  logic       cmd_stop_i,
  input  logic [7:0] cmd_data_i,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       busy_o,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       scl_pad_o,
  output logic       sda_pad_o,
  output logic       scl_padoen_o,
  output logic       sda_padoen_o
);

  localparam int DIV_RAW = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_ACK,
    ST_STOP,
    ST_HOLD
  } state_t;

  state_t           state;
  logic [1:0]       quarter;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             stop_flag;
  logic             ack_sample;
  logic             stall;
  logic             quarter_end;
  logic             accept;

  // Line drive {scl_oen, sda_oen} for a given phase and quarter; 1 = released.
  // START q0 keeps SCL where it was: high from IDLE, low for a repeated START from HOLD.
  function automatic logic [1:0] phase_lines(input state_t st, input logic [1:0] q,
                                             input logic bit_v, input logic scl_now);
    logic [1:0] lines;
    lines = 2'b11;
    case (st)
      ST_START: begin
        case (q)
          2'd0:    lines = {scl_now, 1'b1};
          2'd1:    lines = 2'b11;
          2'd2:    lines = 2'b10;
          default: lines = 2'b00;
        endcase
      end
      ST_DATA: lines = {(q == 2'd1) || (q == 2'd2), bit_v};
      ST_ACK:  lines = {(q == 2'd1) || (q == 2'd2), 1'b1};
      ST_STOP: begin
        case (q)
          2'd0:    lines = 2'b00;
          2'd1:    lines = 2'b10;
          default: lines = 2'b11;
        endcase
      end
      ST_HOLD: lines = 2'b00;
      default: lines = 2'b11;
    endcase
    return lines;
  endfunction

`ifdef SI5340_I2C_STRETCH_EN
  // While we release SCL but the line still reads low, a slave is stretching: hold the quarter.
  assign stall = scl_padoen_o && !scl_pad_i;
`else
  logic unused_scl;
  assign unused_scl = scl_pad_i;
  assign stall      = 1'b0;
`endif

  assign scl_pad_o   = 1'b0;
  assign sda_pad_o   = 1'b0;
  assign quarter_end = (cnt == CNT_LAST) && !stall;
  assign accept      = cmd_valid_i && cmd_ready_o;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      // NOTE: the pad enables sit on the async reset so both lines release the moment arstn_i falls.
      state        <= ST_IDLE;
      quarter      <= 2'd0;
      cnt          <= '0;
      bit_idx      <= 3'd0;
      shreg        <= 8'h00;
      stop_flag    <= 1'b0;
      ack_sample   <= 1'b0;
      scl_padoen_o <= 1'b1;
      sda_padoen_o <= 1'b1;
      cmd_ready_o  <= 1'b1;
      done_o       <= 1'b0;
      ack_err_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere, so every branch below sees the pre-edge register values.
      done_o <= 1'b0;
      if (state == ST_ACK && quarter == 2'd2 && quarter_end) begin
        ack_sample <= sda_pad_i;
      end

      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            shreg       <= cmd_data_i;
            stop_flag   <= cmd_stop_i;
            bit_idx     <= 3'd7;
            quarter     <= 2'd0;
            cnt         <= '0;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (state == ST_IDLE || cmd_start_i) begin
              state <= ST_START;
              {scl_padoen_o, sda_padoen_o} <= phase_lines(ST_START, 2'd0, 1'b1, scl_padoen_o);
            end else begin
              state <= ST_DATA;
              {scl_padoen_o, sda_padoen_o} <= phase_lines(ST_DATA, 2'd0, cmd_data_i[7], scl_padoen_o);
            end
          end
        end

        default: begin
          if (!quarter_end) begin
            if (!stall) cnt <= cnt + 1'b1;
          end else begin
            cnt     <= '0;
            quarter <= quarter + 2'd1;
            if (quarter != 2'd3) begin
              {scl_padoen_o, sda_padoen_o} <=
                phase_lines(state, quarter + 2'd1, shreg[7], scl_padoen_o);
            end else begin
              case (state)
                ST_START: begin
                  state <= ST_DATA;
                  {scl_padoen_o, sda_padoen_o} <= phase_lines(ST_DATA, 2'd0, shreg[7], scl_padoen_o);
                end
                ST_DATA: begin
                  if (bit_idx == 3'd0) begin
                    state <= ST_ACK;
                    {scl_padoen_o, sda_padoen_o} <= phase_lines(ST_ACK, 2'd0, 1'b1, scl_padoen_o);
                  end else begin
                    bit_idx <= bit_idx - 3'd1;
                    shreg   <= {shreg[6:0], 1'b0};
                    {scl_padoen_o, sda_padoen_o} <= phase_lines(ST_DATA, 2'd0, shreg[6], scl_padoen_o);
                  end
                end
                ST_ACK: begin
                  // A NACK is only reported; the requested STOP or HOLD still follows.
                  done_o    <= 1'b1;
                  ack_err_o <= ack_sample;
                  if (stop_flag) begin
                    state <= ST_STOP;
                    {scl_padoen_o, sda_padoen_o} <= phase_lines(ST_STOP, 2'd0, 1'b1, scl_padoen_o);
                  end else begin
                    state       <= ST_HOLD;
                    cmd_ready_o <= 1'b1;
                    {scl_padoen_o, sda_padoen_o} <= phase_lines(ST_HOLD, 2'd0, 1'b1, scl_padoen_o);
                  end
                end
                default: begin
                  state        <= ST_IDLE;
                  cmd_ready_o  <= 1'b1;
                  busy_o       <= 1'b0;
                  scl_padoen_o <= 1'b1;
                  sda_padoen_o <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/si5340_i2c_master.md
# si5340_i2c_master

Write-only I2C byte master that sits directly downstream of the SI5340 configuration loader. It accepts one byte command per handshake (optional START before, optional STOP after), serialises it MSB-first on open-drain SCL/SDA pad signals, samples the slave ACK and reports it. The loader sequences address/register/data bytes; this block owns all bus-level timing.

## Interface
- CLK_FREQ_HZ, 125000000, system clock frequency
- I2C_FREQ_HZ, 400000, target SCL frequency; quarter-period DIV = CLK_FREQ_HZ/(4*I2C_FREQ_HZ), truncated, minimum 1 (78 at defaults)
- clk_i  in  1  system clock
- arstn_i  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  block can accept a command
- cmd_start_i  in  1  issue START (repeated START if bus already owned) before the byte
- cmd_stop_i  in  1  issue STOP after the ACK bit
- cmd_data_i  in  8  byte to transmit, MSB first
- done_o  out  1  one-cycle pulse when a byte's ACK bit completes
- ack_err_o  out  1  ACK bit sampled at last done_o (1 = NACK); held until next done_o
- busy_o  out  1  bus owned by this block (any state except IDLE)
- scl_pad_i, sda_pad_i  in  1  sensed line levels
- scl_pad_o, sda_pad_o  out  1  constant 0
- scl_padoen_o, sda_padoen_o  out  1  active-low drive enable; 1 = released (line high), 0 = pulled low

## Operation
- States: IDLE (both released), START, DATA, ACK, STOP, HOLD (bus owned, SCL low, SDA low).
- Accept on cmd_valid_i && cmd_ready_o; cmd_ready_o = 1 only in IDLE and HOLD. Data, start and stop flags are latched at acceptance.
- IDLE accepts a command with or without cmd_start_i; START is always issued from IDLE.
- HOLD with cmd_start_i: repeated START. HOLD without it: go straight to DATA.
- Each phase is 4 quarters q0..q3, each exactly DIV clocks:
  - START: q0 SDA release; q1 SCL release; q2 SDA low; q3 SCL low.
  - DATA bit: q0 SCL low, SDA = bit (1 = release); q1 SCL release; q2 SCL high; q3 SCL low. Repeat 8 times.
  - ACK: SDA released all quarters; SCL as in DATA; sda_pad_i sampled on the last clock of q2.
  - STOP: q0 SDA low; q1 SCL release; q2 SDA release; q3 idle → IDLE.
- After ACK: STOP if the stop flag is latched, else HOLD. A NACK does not abort; the requested sequence completes and only ack_err_o reports it.
- HOLD persists indefinitely. Only a command or reset leaves it.

## Timing
- Reset values: both padoen = 1, pad_o = 0, cmd_ready_o = 1, done_o = 0, ack_err_o = 0, busy_o = 0, state IDLE.
- q0 of the first phase starts the clock after acceptance. The quarter counter restarts at 0 on every phase entry.
- A byte with START+STOP takes 44·DIV clocks from acceptance to IDLE. done_o pulses on the last clock of ACK q3, which is 40·DIV clocks after acceptance.
- A byte from HOLD without START/STOP takes 36·DIV clocks. done_o pulses on the same clock cmd_ready_o rises in HOLD, so back-to-back commands are accepted on the next edge.
- Reset asserted mid-byte: both lines released combinationally through the async-reset flops within the same cycle. The slave may be left mid-byte; recovery belongs to the loader.

## Configuration
- SI5340_I2C_STRETCH_EN defined: in any quarter where SCL is released, the quarter counter freezes while scl_pad_i == 0. The quarter resumes counting the cycle after SCL reads high.
- Undefined: scl_pad_i ignored; timing is purely counter-driven.

## Test plan
- Reset, then idle 100 cycles → both padoen = 1, cmd_ready_o = 1, busy_o = 0.
- Command 0xE8, start = 1, stop = 0; slave ACKs → SDA on SCL rising edges 1,1,1,0,1,0,0,0; done_o pulse at 40·78 clocks after acceptance; ack_err_o = 0; state HOLD, SCL/SDA low, cmd_ready_o = 1.
- From HOLD send 0x01, stop = 1; slave leaves SDA high at ACK → ack_err_o = 1; STOP completes; padoen both 1 at 36·78+4·78 clocks; busy_o = 0.
- From HOLD send 0xE9 with start = 1 → SDA falls while SCL high (repeated START) before the first data bit; bits 1,1,1,0,1,0,0,1.
- With SI5340_I2C_STRETCH_EN, slave holds scl_pad_i low 500 clocks during bit 3 q1 → byte completes 500 clocks later than nominal. Without the macro, timing is unchanged.
- Assert arstn_i during bit 5 of a byte → same cycle both padoen = 1, done_o = 0; after release a fresh START+0xE8 completes normally.
